// File: rtl/display_pkg.sv
// Shared types and default geometry for the display word fetcher.
package display_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 16;
    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_BPMP_X       = 3;
    localparam int unsigned DEF_BPMP_Y       = 3;
    localparam int unsigned DEF_WORDS_PER_ROW = 4;
    localparam int unsigned DEF_ROWS         = 48;
    localparam int unsigned DEF_BASE_ADDR    = 0;

    localparam int unsigned PIXEL_W      = 10;
    localparam int unsigned PPW          = DEF_DATA_WIDTH << DEF_BPMP_X;
    localparam int unsigned SCREEN_LINES = 480;
    localparam int unsigned COL_W        = (DEF_WORDS_PER_ROW > 1) ? $clog2(DEF_WORDS_PER_ROW) : 1;
    localparam int unsigned ROW_W        = (DEF_ROWS > 1) ? $clog2(DEF_ROWS) : 1;

    // One word slot on screen; out=1 means the beam is outside the displayed region.
    typedef struct packed {
        logic             out;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL
    } fetch_state_t;

    localparam slot_t SLOT_OUT = '{out: 1'b1, row: '0, col: '0};

endpackage

// File: rtl/display_word_fetcher_slot_calc.sv
// Combinational beam-position to slot mapping, next-slot prediction and word address.
module slot_calc
    import display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH              = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH              = DEF_ADDR_WIDTH,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = DEF_BPMP_X,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = DEF_BPMP_Y,
    parameter int unsigned WORDS_PER_ROW           = DEF_WORDS_PER_ROW,
    parameter int unsigned ROWS                    = DEF_ROWS,
    parameter int unsigned BASE_ADDR               = DEF_BASE_ADDR
) (
    input  logic [PIXEL_W-1:0]    pixel_x,
    input  logic [PIXEL_W-1:0]    pixel_y,
    input  slot_t                 slot_reg,
    output slot_t                 cur_slot,
    output slot_t                 next_slot,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    // PPW is a power of two, so the column divide is a shift.
    localparam int unsigned COL_SHIFT = $clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X;

    logic [PIXEL_W-1:0] col_full;
    logic [PIXEL_W-1:0] row_full;
    logic [PIXEL_W:0]   y_inc;
    logic [PIXEL_W:0]   row_inc;

    // Current slot from the beam position; row/col are zeroed when outside.
    always_comb begin
        col_full = pixel_x >> COL_SHIFT;
        row_full = pixel_y >> BITS_PER_MEMORY_PIXEL_Y;
        cur_slot = SLOT_OUT;
        if ((32'(col_full) < WORDS_PER_ROW) && (32'(row_full) < ROWS)) begin
            cur_slot.out = 1'b0;
            cur_slot.row = ROW_W'(row_full);
            cur_slot.col = COL_W'(col_full);
        end
    end

    // Slot to prefetch after the registered one: next column, else column 0 of the upcoming row.
    always_comb begin
        y_inc     = (PIXEL_W + 1)'(pixel_y) + (PIXEL_W + 1)'(1);
        row_inc   = y_inc >> BITS_PER_MEMORY_PIXEL_Y;
        next_slot = '0;
        if (!slot_reg.out && (32'(slot_reg.col) + 32'd1 < WORDS_PER_ROW)) begin
            next_slot.row = slot_reg.row;
            next_slot.col = COL_W'(slot_reg.col + COL_W'(1));
        end else if ((32'(y_inc) >= SCREEN_LINES) || (32'(row_inc) >= ROWS)) begin
            next_slot.row = '0;
        end else begin
            next_slot.row = ROW_W'(row_inc);
        end
        next_addr = ADDR_WIDTH'(BASE_ADDR + 32'(next_slot.row) * WORDS_PER_ROW + 32'(next_slot.col));
    end

endmodule

// File: rtl/display_word_fetcher.sv
// Prefetches one display word ahead of the beam and presents it to the renderer.
module display_word_fetcher
    import display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH              = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH              = DEF_ADDR_WIDTH,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = DEF_BPMP_X,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = DEF_BPMP_Y,
    parameter int unsigned WORDS_PER_ROW           = DEF_WORDS_PER_ROW,
    parameter int unsigned ROWS                    = DEF_ROWS,
    parameter int unsigned BASE_ADDR               = DEF_BASE_ADDR
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic [PIXEL_W-1:0]    pixel_x,
    input  logic [PIXEL_W-1:0]    pixel_y,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pixel_word,
    output logic                  word_valid,
    output logic                  underrun
);

    fetch_state_t          state, state_d;
    slot_t                 slot_q, target_q, target_d;
    slot_t                 cur_slot, next_slot;
    logic [ADDR_WIDTH-1:0] next_addr, addr_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d, word_d;
    logic                  stale_q, stale_d, pend_q, pend_d;
    logic                  req_d, valid_d, und_d;
    logic                  boundary, fire;
    slot_t                 cmp_slot;

    slot_calc #(
        .DATA_WIDTH             (DATA_WIDTH),
        .ADDR_WIDTH             (ADDR_WIDTH),
        .BITS_PER_MEMORY_PIXEL_X(BITS_PER_MEMORY_PIXEL_X),
        .BITS_PER_MEMORY_PIXEL_Y(BITS_PER_MEMORY_PIXEL_Y),
        .WORDS_PER_ROW          (WORDS_PER_ROW),
        .ROWS                   (ROWS),
        .BASE_ADDR              (BASE_ADDR)
    ) u_slot_calc (
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .slot_reg (slot_q),
        .cur_slot (cur_slot),
        .next_slot(next_slot),
        .next_addr(next_addr)
    );

    // Boundary = entering a new in-region slot; a boundary that coincided with the
    // ack is replayed one cycle later against the registered slot.
    assign boundary = !cur_slot.out && (cur_slot != slot_q);
    assign fire     = !cur_slot.out && (boundary || pend_q);
    assign cmp_slot = boundary ? cur_slot : slot_q;

    // State and datapath registers.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            slot_q     <= SLOT_OUT;
            target_q   <= SLOT_OUT;
            buf_q      <= '0;
            stale_q    <= 1'b0;
            pend_q     <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            pixel_word <= '0;
            word_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            slot_q     <= cur_slot;
            target_q   <= target_d;
            buf_q      <= buf_d;
            stale_q    <= stale_d;
            pend_q     <= pend_d;
            mem_req    <= req_d;
            mem_addr   <= addr_d;
            pixel_word <= word_d;
            word_valid <= valid_d;
            underrun   <= und_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = REQ;
            REQ:     if (mem_ack) state_d = stale_q ? IDLE : FULL;
            FULL:    if (fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        target_d = target_q;
        buf_d    = buf_q;
        stale_d  = stale_q;
        pend_d   = pend_q;
        req_d    = mem_req;
        addr_d   = mem_addr;
        word_d   = pixel_word;
        valid_d  = word_valid;
        und_d    = underrun;
        case (state)
            IDLE: begin
                target_d = next_slot;
                addr_d   = next_addr;
                req_d    = 1'b1;
                if (boundary) begin
                    valid_d = 1'b0;
                    und_d   = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack && !stale_q) begin
                    buf_d  = mem_rdata;
                    req_d  = 1'b0;
                    pend_d = boundary;
                end else begin
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        stale_d = 1'b0;
                    end
                    if (boundary) begin
                        valid_d = 1'b0;
                        und_d   = 1'b1;
                        if (!mem_ack) stale_d = 1'b1;
                    end
                end
            end
            FULL: begin
                if (fire) begin
                    pend_d = 1'b0;
                    if (target_q == cmp_slot) begin
                        word_d  = buf_q;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        und_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Outside the region the renderer sees blank words.
        if (cur_slot.out) begin
            word_d  = '0;
            valid_d = 1'b0;
            pend_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_display_word_fetcher.sv
// Directed bench for display_word_fetcher with a variable-latency memory responder.
module tb_display_word_fetcher;

    logic        CLK_50 = 1'b0;
    logic        RESET;
    logic [9:0]  pixel_x, pixel_y;
    logic        mem_req, mem_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata, pixel_word;
    logic        word_valid, underrun;

    logic [15:0] mem [256];
    int          lat;
    int          cnt;
    int          total = 0;
    int          bad = 0;

    display_word_fetcher dut (
        .CLK_50    (CLK_50),
        .RESET     (RESET),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pixel_word(pixel_word),
        .word_valid(word_valid),
        .underrun  (underrun)
    );

    always #10 CLK_50 = ~CLK_50;

    // Memory: acknowledges a held request after lat cycles with a one-cycle pulse.
    always @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            cnt       <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_ack) begin
                cnt <= 0;
            end else if (mem_req) begin
                if (cnt + 1 >= lat) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= mem[mem_addr];
                    cnt       <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic step(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        tick();
    endtask

    // Bounded wait for a request, then check its address.
    task automatic wait_req(input string tag, input logic [7:0] exp_addr);
        for (int i = 0; i < 50 && !mem_req; i++) tick();
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    endtask

    initial begin
        mem[0] = 16'hA5A5;
        for (int i = 1; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        lat     = 2;
        RESET   = 1'b1;
        pixel_x = 10'd700;
        pixel_y = 10'd0;
        tick();
        tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_word", 32'(pixel_word), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        RESET = 1'b0;

        // 1: first prefetch from outside the region, then enter slot (0,0)
        wait_req("t1_first", 8'd0);
        repeat (6) tick();
        step(0, 0);
        check("t1_word", 32'(pixel_word), 32'h0000A5A5);
        check("t1_valid", 32'(word_valid), 32'd1);
        wait_req("t1_next", 8'd1);

        // 2: sweep line 0 with ack latency 3
        lat = 3;
        for (int x = 1; x <= 512; x++) begin
            step(x, 0);
            if (x == 128) check("t2_w1", 32'(pixel_word), 32'h1001);
            if (x == 256) check("t2_w2", 32'(pixel_word), 32'h1002);
            if (x == 384) check("t2_w3", 32'(pixel_word), 32'h1003);
            if (x == 384) check("t2_v3", 32'(word_valid), 32'd1);
            if (x == 386) check("t2_wrap_req", 32'(mem_req), 32'd1);
            if (x == 386) check("t2_wrap_addr", 32'(mem_addr), 32'd0);
            if (x == 511) check("t2_underrun", 32'(underrun), 32'd0);
            if (x == 512) check("t2_out_valid", 32'(word_valid), 32'd0);
            if (x == 512) check("t2_out_word", 32'(pixel_word), 32'd0);
        end

        // 3: last line of row 0 prefetches row 1
        step(0, 7);
        check("t3_w0", 32'(pixel_word), 32'h0000A5A5);
        for (int x = 1; x <= 512; x++) begin
            step(x, 7);
            if (x == 386) check("t3_req", 32'(mem_req), 32'd1);
            if (x == 386) check("t3_addr", 32'(mem_addr), 32'd4);
        end
        step(0, 8);
        check("t3_word", 32'(pixel_word), 32'h1004);
        check("t3_valid", 32'(word_valid), 32'd1);

        // 5: slow memory causes an underrun and a discarded late ack
        for (int x = 1; x <= 383; x++) begin
            step(x, 8);
            if (x == 10) lat = 200;
            if (x == 128) check("t5_w1", 32'(pixel_word), 32'h1005);
            if (x == 256) check("t5_underrun", 32'(underrun), 32'd1);
            if (x == 256) check("t5_valid", 32'(word_valid), 32'd0);
            if (x == 383) check("t5_rereq", 32'(mem_req), 32'd1);
            if (x == 383) check("t5_readdr", 32'(mem_addr), 32'd7);
        end

        // 6: asynchronous reset while a request is outstanding
        RESET = 1'b1;
        #1;
        check("t6_req", 32'(mem_req), 32'd0);
        check("t6_valid", 32'(word_valid), 32'd0);
        check("t6_underrun", 32'(underrun), 32'd0);
        lat     = 2;
        pixel_x = 10'd600;
        pixel_y = 10'd382;
        tick();
        tick();
        RESET = 1'b0;
        wait_req("t6_first", 8'd188);
        repeat (6) tick();

        // 4: last region line wraps the prefetch to row 0
        step(0, 383);
        check("t4_w0", 32'(pixel_word), 32'h10BC);
        for (int x = 1; x <= 512; x++) begin
            step(x, 383);
            if (x == 128) check("t4_w1", 32'(pixel_word), 32'h10BD);
            if (x == 256) check("t4_w2", 32'(pixel_word), 32'h10BE);
            if (x == 384) check("t4_w3", 32'(pixel_word), 32'h10BF);
            if (x == 386) check("t4_wrap_req", 32'(mem_req), 32'd1);
            if (x == 386) check("t4_wrap_addr", 32'(mem_addr), 32'd0);
            if (x == 512) check("t4_xout_valid", 32'(word_valid), 32'd0);
            if (x == 512) check("t4_xout_word", 32'(pixel_word), 32'd0);
        end
        step(0, 384);
        check("t4_yout_valid", 32'(word_valid), 32'd0);
        check("t4_yout_word", 32'(pixel_word), 32'd0);
        check("t4_underrun", 32'(underrun), 32'd0);
        step(0, 0);
        check("t4_top_word", 32'(pixel_word), 32'h0000A5A5);
        check("t4_top_valid", 32'(word_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
